// File: rtl/ahb_mem_slave.sv
// AHB-Lite slave in front of an external dual-port RAM, with configurable wait states and write-to-read forwarding.
// Define AHB_MEM_SLAVE_RANGE_ERR_EN to answer ERROR for addresses outside the decoded window.
module ahb_mem_slave #(
  parameter int          DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  localparam int         AW          = $clog2(DEPTH),
  localparam int         NB          = DATA_W / 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic [AW-1:0]     mem_waddr,
  output logic [AW-1:0]     mem_raddr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [NB-1:0]     mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int         OFF_W    = $clog2(NB);
  localparam int         TOP      = OFF_W + AW;
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);
  localparam logic [2:0] WS_LOAD  = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t            state, state_nxt;
  logic [2:0]        wait_cnt, wait_cnt_nxt;
  logic [AW-1:0]     addr_q;
  logic [OFF_W-1:0]  off_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic              fwd_hit_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [NB-1:0]     fwd_be_q;

  logic              accept, size_err, range_err, data_ok;
  logic [OFF_W-1:0]  low_mask;
  logic [NB-1:0]     be_lane;
  logic              unused_ok;

  assign unused_ok = ^{HBURST, HADDR[31:TOP], BASE_ADDR};

  assign accept   = HSEL && HREADY && HTRANS[1];
  assign low_mask = OFF_W'((32'd1 << HSIZE) - 32'd1);
  assign size_err = (HSIZE > MAX_SIZE) || ((HADDR[OFF_W-1:0] & low_mask) != '0);

`ifdef AHB_MEM_SLAVE_RANGE_ERR_EN
  assign range_err = (HADDR[31:TOP] != BASE_ADDR[31:TOP]);
`else
  assign range_err = 1'b0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_WAIT: begin
        if (wait_cnt == 3'd0) state_nxt = ST_DATA;
        else                  wait_cnt_nxt = wait_cnt - 3'd1;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all drive HREADYOUT high, so a new address phase may land here.
        state_nxt = ST_IDLE;
        if (accept) begin
          if (size_err || range_err) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WS_LOAD;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      addr_q     <= '0;
      off_q      <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_be_q   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        addr_q  <= HADDR[OFF_W +: AW];
        off_q   <= HADDR[OFF_W-1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
      // The RAM returns stale data when written and read in the same cycle; remember the write bytes.
      if (mem_re) begin
        fwd_hit_q  <= mem_we && (mem_waddr == mem_raddr);
        fwd_data_q <= HWDATA;
        fwd_be_q   <= mem_be;
      end
    end
  end

  always_comb begin
    be_lane = '0;
    for (int i = 0; i < NB; i++)
      be_lane[i] = (i >= int'(off_q)) && (i < int'(off_q) + (1 << size_q));
  end

  // Outputs are masked by HRESET so an in-flight transfer is dropped in the reset cycle itself.
  assign data_ok   = (state == ST_DATA) && !HRESET;
  assign HREADYOUT = HRESET || !((state == ST_WAIT) || (state == ST_ERR1));
  assign HRESP     = !HRESET && ((state == ST_ERR1) || (state == ST_ERR2));

  assign mem_we    = data_ok && write_q;
  assign mem_waddr = mem_we ? addr_q  : '0;
  assign mem_be    = mem_we ? be_lane : '0;
  assign mem_wdata = mem_we ? HWDATA  : '0;

  assign mem_re    = accept && !HWRITE && !size_err && !range_err && !HRESET;
  assign mem_raddr = mem_re ? HADDR[OFF_W +: AW] : '0;

  always_comb begin
    HRDATA = '0;
    if (data_ok && !write_q)
      for (int i = 0; i < NB; i++)
        HRDATA[8*i +: 8] = (fwd_hit_q && fwd_be_q[i]) ? fwd_data_q[8*i +: 8] : mem_rdata[8*i +: 8];
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench for ahb_mem_slave: a zero-wait and a two-wait instance share one bus,
// the driver queues expected responses and memory strobes, a negedge monitor compares them.
module tb_ahb_mem_slave;
  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

  typedef struct { string name; logic resp; logic [31:0] rdata; int waits; } rsp_t;
  typedef struct { string name; logic [AW-1:0] waddr; logic [3:0] be; logic [31:0] wdata; } wr_t;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic          hreset, hsel, hwrite, use_ws2;
  logic [31:0]   haddr, hwdata, wdata_pipe;
  logic [1:0]    htrans;
  logic [2:0]    hsize, hburst;
  logic          hready, hsel0, hsel2;
  logic          ro0, ro2, resp0, resp2, we0, we2, re0, re2;
  logic [31:0]   rdata0, rdata2, wdata0, wdata2, mrdata0, mrdata2;
  logic [AW-1:0] waddr0, waddr2, raddr0, raddr2;
  logic [3:0]    be0, be2;
  logic [31:0]   ram0 [DEPTH];
  logic [31:0]   ram2 [DEPTH];

  assign hsel0  = hsel && !use_ws2;
  assign hsel2  = hsel && use_ws2;
  assign hready = use_ws2 ? ro2 : ro0;

  ahb_mem_slave #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(ro0), .HRESP(resp0),
    .HRDATA(rdata0), .mem_waddr(waddr0), .mem_raddr(raddr0), .mem_we(we0), .mem_re(re0),
    .mem_be(be0), .mem_wdata(wdata0), .mem_rdata(mrdata0));

  ahb_mem_slave #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(ro2), .HRESP(resp2),
    .HRDATA(rdata2), .mem_waddr(waddr2), .mem_raddr(raddr2), .mem_we(we2), .mem_re(re2),
    .mem_be(be2), .mem_wdata(wdata2), .mem_rdata(mrdata2));

  // Read-before-write RAM models: a same-cycle read returns the old word.
  always @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < DEPTH; i++) begin ram0[i] <= '0; ram2[i] <= '0; end
      mrdata0 <= '0;
      mrdata2 <= '0;
    end else begin
      if (re0) mrdata0 <= ram0[raddr0];
      if (re2) mrdata2 <= ram2[raddr2];
      for (int b = 0; b < 4; b++) begin
        if (we0 && be0[b]) ram0[waddr0][8*b +: 8] <= wdata0[8*b +: 8];
        if (we2 && be2[b]) ram2[waddr2][8*b +: 8] <= wdata2[8*b +: 8];
      end
    end
  end

  logic          s_ro, s_resp, s_we, s_re;
  logic [31:0]   s_rdata, s_wdata;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [3:0]    s_be;
  assign s_ro    = use_ws2 ? ro2    : ro0;
  assign s_resp  = use_ws2 ? resp2  : resp0;
  assign s_rdata = use_ws2 ? rdata2 : rdata0;
  assign s_we    = use_ws2 ? we2    : we0;
  assign s_re    = use_ws2 ? re2    : re0;
  assign s_wdata = use_ws2 ? wdata2 : wdata0;
  assign s_waddr = use_ws2 ? waddr2 : waddr0;
  assign s_raddr = use_ws2 ? raddr2 : raddr0;
  assign s_be    = use_ws2 ? be2    : be0;

  rsp_t          rsp_q[$];
  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_rsp(input string n, input logic resp, input logic [31:0] rd, input int waits);
    rsp_q.push_back('{n, resp, rd, waits});
  endtask

  task automatic exp_wr(input string n, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_q.push_back('{n, a, be, d});
  endtask

  // Monitor: strobes and responses are compared against the queue heads as they appear.
  logic in_dp = 1'b0;
  int   wcnt = 0;
  rsp_t r;
  wr_t  w;
  logic [AW-1:0] ra;
  always @(negedge hclk) begin
    if (hreset) begin
      check("reset outputs", 64'({s_ro, s_resp, s_rdata, s_we, s_re, s_be, s_waddr, s_raddr}),
            64'({1'b1, 59'd0}));
      if (in_dp && rsp_q.size() > 0) r = rsp_q.pop_front();
      in_dp = 1'b0;
    end else begin
      if (s_we) begin
        if (wr_q.size() == 0) check("mem_we while none expected", 64'(s_we), 64'd0);
        else begin
          w = wr_q.pop_front();
          check({w.name, " mem write"}, 64'({s_waddr, s_be, s_wdata}), 64'({w.waddr, w.be, w.wdata}));
        end
      end
      if (s_re) begin
        if (rd_q.size() == 0) check("mem_re while none expected", 64'(s_re), 64'd0);
        else begin
          ra = rd_q.pop_front();
          check("mem_raddr", 64'(s_raddr), 64'(ra));
        end
      end
      if (in_dp) begin
        if (!s_ro) begin
          wcnt++;
          if (rsp_q.size() > 0 && rsp_q[0].resp) check({rsp_q[0].name, " err1 resp"}, 64'(s_resp), 64'd1);
        end else if (rsp_q.size() == 0) begin
          check("response while none expected", 64'(s_ro), 64'd0);
          in_dp = 1'b0;
        end else begin
          r = rsp_q.pop_front();
          check({r.name, " resp"}, 64'(s_resp), 64'(r.resp));
          check({r.name, " rdata"}, 64'(s_rdata), 64'(r.rdata));
          check({r.name, " waits"}, 64'(wcnt), 64'(r.waits));
          in_dp = 1'b0;
        end
      end
      if (!in_dp && hready && hsel && htrans != T_IDLE) begin
        in_dp = 1'b1;
        wcnt  = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge hclk);
    while (!hready && n < 40) begin n++; @(negedge hclk); end
    check("hready within bound", 64'(hready), 64'd1);
    @(posedge hclk); #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                       input logic [2:0] sz, input logic [31:0] wd);
    hsel   = (tr != T_IDLE);
    htrans = tr;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    hwdata = wdata_pipe;
    wait_ready();
    wdata_pipe = (tr[1] && wr) ? wd : '0;
  endtask

  task automatic idle();
    drive(T_IDLE, 32'h0, 1'b0, 3'd2, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hreset = 1'b1; hsel = 1'b0; htrans = T_IDLE; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; hwdata = '0; wdata_pipe = '0; use_ws2 = 1'b0;
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b0;

    // Single write then read of 0x10.
    exp_wr("wr 0x10", 10'd4, 4'hF, 32'hDEADBEEF); exp_rsp("wr 0x10", 1'b0, 32'h0, 0);
    drive(T_NONSEQ, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    idle();
    rd_q.push_back(10'd4); exp_rsp("rd 0x10", 1'b0, 32'hDEADBEEF, 0);
    drive(T_NONSEQ, 32'h10, 1'b0, 3'd2, 32'h0);
    idle();

    // Pipelined write/read to the same word must forward the write data.
    exp_wr("wr 0x20", 10'd8, 4'hF, 32'h11223344); exp_rsp("wr 0x20", 1'b0, 32'h0, 0);
    drive(T_NONSEQ, 32'h20, 1'b1, 3'd2, 32'h11223344);
    rd_q.push_back(10'd8); exp_rsp("rd 0x20 fwd", 1'b0, 32'h11223344, 0);
    drive(T_NONSEQ, 32'h20, 1'b0, 3'd2, 32'h0);
    exp_wr("wrb 0x21", 10'd8, 4'b0010, 32'h0000AB00); exp_rsp("wrb 0x21", 1'b0, 32'h0, 0);
    drive(T_NONSEQ, 32'h21, 1'b1, 3'd0, 32'h0000AB00);
    rd_q.push_back(10'd8); exp_rsp("rd 0x20 merge", 1'b0, 32'h1122AB44, 0);
    drive(T_NONSEQ, 32'h20, 1'b0, 3'd2, 32'h0);
    exp_wr("wrh 0x22", 10'd8, 4'b1100, 32'hCAFE0000); exp_rsp("wrh 0x22", 1'b0, 32'h0, 0);
    drive(T_NONSEQ, 32'h22, 1'b1, 3'd1, 32'hCAFE0000);
    idle();
    rd_q.push_back(10'd8); exp_rsp("rd 0x20 b2b", 1'b0, 32'hCAFEAB44, 0);
    drive(T_NONSEQ, 32'h20, 1'b0, 3'd2, 32'h0);
    rd_q.push_back(10'd8); exp_rsp("rdh 0x22 b2b", 1'b0, 32'hCAFEAB44, 0);
    drive(T_NONSEQ, 32'h22, 1'b0, 3'd1, 32'h0);
    idle();

    // Size and alignment errors; the transfer after ERR2 proceeds normally.
    exp_rsp("err size3", 1'b1, 32'h0, 1);
    drive(T_NONSEQ, 32'h30, 1'b1, 3'd3, 32'h12345678);
    idle();
    exp_rsp("err 0x02 word", 1'b1, 32'h0, 1);
    drive(T_NONSEQ, 32'h02, 1'b0, 3'd2, 32'h0);
    rd_q.push_back(10'd4); exp_rsp("rd after err", 1'b0, 32'hDEADBEEF, 0);
    drive(T_NONSEQ, 32'h10, 1'b0, 3'd2, 32'h0);
    exp_rsp("err 0x01 half", 1'b1, 32'h0, 1);
    drive(T_NONSEQ, 32'h01, 1'b1, 3'd1, 32'h0000FFFF);
    idle();

    // Address just past the window.
`ifdef AHB_MEM_SLAVE_RANGE_ERR_EN
    exp_rsp("wr 0x1000 range", 1'b1, 32'h0, 1);
    drive(T_NONSEQ, 32'h1000, 1'b1, 3'd2, 32'h55AA55AA);
    idle();
    rd_q.push_back(10'd0); exp_rsp("rd 0x0", 1'b0, 32'h0, 0);
`else
    exp_wr("wr 0x1000 wrap", 10'd0, 4'hF, 32'h55AA55AA); exp_rsp("wr 0x1000 wrap", 1'b0, 32'h0, 0);
    drive(T_NONSEQ, 32'h1000, 1'b1, 3'd2, 32'h55AA55AA);
    idle();
    rd_q.push_back(10'd0); exp_rsp("rd 0x0", 1'b0, 32'h55AA55AA, 0);
`endif
    drive(T_NONSEQ, 32'h0, 1'b0, 3'd2, 32'h0);
    idle();

    // Two-wait-state instance: INCR4 write burst, then INCR4 read burst with a BUSY after beat 2.
    use_ws2 = 1'b1;
    hburst  = 3'b011;
    for (int i = 0; i < 4; i++) begin
      exp_wr($sformatf("burst wr %0d", i), 10'(16 + i), 4'hF, 32'hA0A0A0A0 + 32'(i));
      exp_rsp($sformatf("burst wr %0d", i), 1'b0, 32'h0, 2);
      drive(i == 0 ? T_NONSEQ : T_SEQ, 32'h40 + 32'(4 * i), 1'b1, 3'd2, 32'hA0A0A0A0 + 32'(i));
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        exp_rsp("burst busy", 1'b0, 32'h0, 0);
        drive(T_BUSY, 32'h48, 1'b0, 3'd2, 32'h0);
      end
      rd_q.push_back(10'(16 + i));
      exp_rsp($sformatf("burst rd %0d", i), 1'b0, 32'hA0A0A0A0 + 32'(i), 2);
      drive(i == 0 ? T_NONSEQ : T_SEQ, 32'h40 + 32'(4 * i), 1'b0, 3'd2, 32'h0);
    end
    idle();
    hburst = 3'd0;

    // Reset during the second wait cycle of a write: the write must never reach the RAM.
    exp_rsp("wr 0x50 aborted", 1'b0, 32'h0, 2);
    drive(T_NONSEQ, 32'h50, 1'b1, 3'd2, 32'h99999999);
    hsel = 1'b0; htrans = T_IDLE; hwdata = wdata_pipe;
    @(posedge hclk); #1;
    hreset = 1'b1;
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;
    wdata_pipe = '0;
    rd_q.push_back(10'd20); exp_rsp("rd 0x50 after reset", 1'b0, 32'h0, 2);
    drive(T_NONSEQ, 32'h50, 1'b0, 3'd2, 32'h0);
    idle();

    repeat (3) @(posedge hclk);
    check("response queue drained", 64'(rsp_q.size()), 64'd0);
    check("write queue drained", 64'(wr_q.size()), 64'd0);
    check("read queue drained", 64'(rd_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
